obi_arbiter_2_to_1: RTL

Two-controller to one-slave OBI arbiter with round-robin arbitration and in-order response routing. It shares one OBI slave port, such as a memory or a peripheral bus demux input, between two OBI masters, for example an instruction fetch unit and a load/store unit. Multiple transactions may be outstanding, up to a configured limit. A small ID FIFO returns each response to the master that issued it.

---
 rtl/obi_arbiter_2_to_1.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/obi_arbiter_2_to_1.sv
// Two-master to one-slave OBI arbiter: round-robin address-phase arbitration with a
// request lock until grant, and an ID FIFO that routes in-order responses back.
module obi_arbiter_2_to_1 #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        port_req_o,
    input  logic        port_gnt_i,
    output logic [31:0] port_addr_o,
    output logic        port_we_o,
    output logic [3:0]  port_be_o,
    output logic [31:0] port_wdata_o,
    input  logic        port_rvalid_i,
    input  logic [31:0] port_rdata_i,

    output logic        spurious_rsp_o
);

    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

    logic                       last_winner_q, last_winner_d;
    logic                       lock_q, lock_d;
    logic                       lock_id_q, lock_id_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]            count_q, count_d;

    logic sel;
    logic full;
    logic hs;
    logic pop;
    logic head;

    always_comb begin
        if (lock_q) begin
            sel = lock_id_q;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
            sel = ~last_winner_q;
        end else begin
            sel = last_winner_q;
        end
    end

    // Full is taken from registered count only, so a same-cycle pop never unblocks a push
    // and port_rvalid_i has no path into the request side.
    assign full = (count_q == CntMax);

    assign port_req_o   = (sel ? m1_req_i : m0_req_i) && !full;
    assign port_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign port_we_o    = sel ? m1_we_i    : m0_we_i;
    assign port_be_o    = sel ? m1_be_i    : m0_be_i;
    assign port_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign hs       = port_req_o && port_gnt_i;
    assign m0_gnt_o = hs && !sel;
    assign m1_gnt_o = hs && sel;

    assign pop            = port_rvalid_i && (count_q != '0);
    assign head           = id_q[rd_ptr_q];
    assign spurious_rsp_o = port_rvalid_i && (count_q == '0);

    assign m0_rvalid_o = pop && !head;
    assign m1_rvalid_o = pop && head;
    assign m0_rdata_o  = m0_rvalid_o ? port_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? port_rdata_i : '0;

    always_comb begin
        last_winner_d = last_winner_q;
        lock_d        = lock_q;
        lock_id_d     = lock_id_q;
        id_d          = id_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (hs) begin
            id_d[wr_ptr_q] = sel;
            wr_ptr_d       = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            last_winner_d  = sel;
            lock_d         = 1'b0;
        end else if (port_req_o) begin
            // Hold the presented request until the slave grants it.
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({hs, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_winner_q <= 1'b1;
            lock_q        <= 1'b0;
            lock_id_q     <= 1'b0;
            id_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            lock_q        <= lock_d;
            lock_id_q     <= lock_id_d;
            id_q          <= id_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule
